cmp_tree: RTL and testbench

CMP_TREE -- requirements
Module: cmp_tree

---
 rtl/cmp_tree.sv | 127 ++++++++++++
 tb/tb_cmp_tree.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_tree.sv
`timescale 1ns/1ps
// Pipelined signed min/max reduction tree with a single global advance enable.
// Define CMP_TREE_IDX_EN to add the idx_o port and per-stage winner-index registers.
module cmp_tree #(
   parameter int WORD_LEN = 16,
   parameter int N_IN     = 8,
   localparam int LEVELS  = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cmp_type_i,
   input  logic [N_IN*WORD_LEN-1:0]   x_i,
   input  logic                       s_valid_i,
   output logic                       s_ready_o,
   output logic signed [WORD_LEN-1:0] y_o,
`ifdef CMP_TREE_IDX_EN
   output logic [IDX_W-1:0]           idx_o,
`endif
   output logic                       m_valid_o,
   input  logic                       m_ready_i
);

   // Number of live entries after l pairing levels.
   function automatic int lvl_cnt(input int l);
      return (N_IN + (1 << l) - 1) >> l;
   endfunction

   logic signed [WORD_LEN-1:0] dat_q [LEVELS][N_IN];
   logic signed [WORD_LEN-1:0] dat_d [LEVELS][N_IN];
   logic                       mode_q [LEVELS];
   logic                       mode_d [LEVELS];
   logic [LEVELS-1:0]          vld_q;
   logic [LEVELS-1:0]          vld_d;
`ifdef CMP_TREE_IDX_EN
   logic [IDX_W-1:0]           idx_q [LEVELS][N_IN];
   logic [IDX_W-1:0]           idx_d [LEVELS][N_IN];
   logic [IDX_W-1:0]           ia;
   logic [IDX_W-1:0]           ib;
`endif
   logic signed [WORD_LEN-1:0] a;
   logic signed [WORD_LEN-1:0] b;
   logic                       m;
   logic                       take_b;
   logic                       adv;

   assign adv       = ~m_valid_o | m_ready_i;
   assign s_ready_o = adv;

   // Next state is forced to zero under reset so one register process covers both cases.
   always_comb begin
      a      = '0;
      b      = '0;
      m      = 1'b0;
      take_b = 1'b0;
      vld_d  = '0;
`ifdef CMP_TREE_IDX_EN
      ia = '0;
      ib = '0;
`endif
      for (int l = 0; l < LEVELS; l++) begin
         mode_d[l] = 1'b0;
         for (int j = 0; j < N_IN; j++) begin
            dat_d[l][j] = '0;
`ifdef CMP_TREE_IDX_EN
            idx_d[l][j] = '0;
`endif
         end
      end
      if (!rst_i) begin
         for (int l = 0; l < LEVELS; l++) begin
            if (l == 0) begin
               m        = cmp_type_i;
               vld_d[0] = s_valid_i;
            end else begin
               m        = mode_q[l-1];
               vld_d[l] = vld_q[l-1];
            end
            mode_d[l] = m;
            for (int j = 0; j < N_IN; j++) begin
               if (j < lvl_cnt(l + 1)) begin
                  take_b = 1'b0;
                  if (l == 0) a = x_i[2*j*WORD_LEN +: WORD_LEN];
                  else        a = dat_q[l-1][2*j];
`ifdef CMP_TREE_IDX_EN
                  if (l == 0) ia = IDX_W'(2*j);
                  else        ia = idx_q[l-1][2*j];
`endif
                  // Odd last entry has no partner and passes through unchanged.
                  if (2*j + 1 < lvl_cnt(l)) begin
                     if (l == 0) b = x_i[(2*j+1)*WORD_LEN +: WORD_LEN];
                     else        b = dat_q[l-1][2*j+1];
`ifdef CMP_TREE_IDX_EN
                     if (l == 0) ib = IDX_W'(2*j + 1);
                     else        ib = idx_q[l-1][2*j+1];
`endif
                     // Strict compare keeps the left entry on ties.
                     take_b = m ? (b > a) : (b < a);
                  end
                  dat_d[l][j] = take_b ? b : a;
`ifdef CMP_TREE_IDX_EN
                  idx_d[l][j] = take_b ? ib : ia;
`endif
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || adv) begin
         dat_q  <= dat_d;
         mode_q <= mode_d;
         vld_q  <= vld_d;
`ifdef CMP_TREE_IDX_EN
         idx_q  <= idx_d;
`endif
      end
   end

   assign y_o       = dat_q[LEVELS-1][0];
   assign m_valid_o = vld_q[LEVELS-1];
`ifdef CMP_TREE_IDX_EN
   assign idx_o     = idx_q[LEVELS-1][0];
`endif

endmodule

// File: tb/tb_cmp_tree.sv
`timescale 1ns/1ps
// Bench for cmp_tree: directed vector table, latency, stall, reset and random backpressure,
// with a 4-input and a 5-input instance checked through per-instance scoreboards.
module tb_cmp_tree;
   localparam int W = 16;
   typedef logic signed [W-1:0] word_t;
   typedef struct { word_t y; logic [2:0] idx; } exp_t;
   typedef struct { bit big; logic mode; word_t x [5]; word_t y; logic [2:0] idx; } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic mode4, s_valid4, s_ready4, m_valid4, m_ready4;
   logic mode5, s_valid5, s_ready5, m_valid5, m_ready5;
   logic [4*W-1:0] x4;
   logic [5*W-1:0] x5;
   word_t y4, y5;
`ifdef CMP_TREE_IDX_EN
   logic [1:0] idx4;
   logic [2:0] idx5;
`endif

   exp_t q4[$];
   exp_t q5[$];
   vec_t tbl [12];
   vec_t rv;
   exp_t re, me;
   int   checks = 0;
   int   failures = 0;
   bit   rnd_done;

   always #5 clk = ~clk;

   cmp_tree #(.WORD_LEN(W), .N_IN(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .cmp_type_i(mode4), .x_i(x4), .s_valid_i(s_valid4),
      .s_ready_o(s_ready4), .y_o(y4),
`ifdef CMP_TREE_IDX_EN
      .idx_o(idx4),
`endif
      .m_valid_o(m_valid4), .m_ready_i(m_ready4)
   );

   cmp_tree #(.WORD_LEN(W), .N_IN(5)) u_dut5 (
      .clk_i(clk), .rst_i(rst), .cmp_type_i(mode5), .x_i(x5), .s_valid_i(s_valid5),
      .s_ready_o(s_ready5), .y_o(y5),
`ifdef CMP_TREE_IDX_EN
      .idx_o(idx5),
`endif
      .m_valid_o(m_valid5), .m_ready_i(m_ready5)
   );

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t model(input word_t x [5], input int n, input logic mode);
      exp_t e;
      e.y   = x[0];
      e.idx = 3'd0;
      for (int k = 1; k < n; k++) begin
         if (mode ? (x[k] > e.y) : (x[k] < e.y)) begin
            e.y   = x[k];
            e.idx = 3'(k);
         end
      end
      return e;
   endfunction

   task automatic set_vec(input int i, input bit big, input logic mode, input int x0,
                          input int x1, input int x2, input int x3, input int x4v,
                          input int y, input int idx);
      tbl[i].big  = big;
      tbl[i].mode = mode;
      tbl[i].x[0] = word_t'(x0);
      tbl[i].x[1] = word_t'(x1);
      tbl[i].x[2] = word_t'(x2);
      tbl[i].x[3] = word_t'(x3);
      tbl[i].x[4] = word_t'(x4v);
      tbl[i].y    = word_t'(y);
      tbl[i].idx  = 3'(idx);
   endtask

   // Called just after a rising edge; returns just after the capturing edge.
   task automatic send(input vec_t v, input exp_t e);
      int guard;
      guard = 0;
      if (v.big) begin
         mode5 = v.mode;
         for (int k = 0; k < 5; k++) x5[k*W +: W] = v.x[k];
         s_valid5 = 1'b1;
      end else begin
         mode4 = v.mode;
         for (int k = 0; k < 4; k++) x4[k*W +: W] = v.x[k];
         s_valid4 = 1'b1;
      end
      @(negedge clk);
      while (!(v.big ? s_ready5 : s_ready4) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("send timeout", 1, 0);
      else if (v.big) q5.push_back(e);
      else q4.push_back(e);
      @(posedge clk);
      #1;
      s_valid4 = 1'b0;
      s_valid5 = 1'b0;
   endtask

   function automatic exp_t tbl_exp(input int i);
      exp_t e;
      e.y   = tbl[i].y;
      e.idx = tbl[i].idx;
      return e;
   endfunction

   task automatic latency(input int i, input int lat);
      send(tbl[i], tbl_exp(i));
      for (int c = 1; c <= lat + 1; c++) begin
         @(negedge clk);
         if (tbl[i].big) check("latency m_valid5", m_valid5, (c == lat));
         else            check("latency m_valid4", m_valid4, (c == lat));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q4.size() != 0 || q5.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain q4 left", q4.size(), 0);
      check("drain q5 left", q5.size(), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic word_t rnd_word();
      case ($urandom_range(0, 5))
         0:       return 16'sh8000;
         1:       return 16'sh7fff;
         default: return word_t'($urandom_range(0, 16)) - 16'sd8;
      endcase
   endfunction

   // Scoreboard consumer: one pop per output handshake.
   always @(negedge clk) begin
      if (!rst && m_valid4 && m_ready4) begin
         if (q4.size() == 0) check("dut4 unexpected result", 1, 0);
         else begin
            me = q4.pop_front();
            check("dut4 y", y4, me.y);
`ifdef CMP_TREE_IDX_EN
            check("dut4 idx", idx4, me.idx);
`endif
         end
      end
      if (!rst && m_valid5 && m_ready5) begin
         if (q5.size() == 0) check("dut5 unexpected result", 1, 0);
         else begin
            me = q5.pop_front();
            check("dut5 y", y5, me.y);
`ifdef CMP_TREE_IDX_EN
            check("dut5 idx", idx5, me.idx);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      set_vec(0,  0, 1'b1, 3, -7, 12, 5, 0, 12, 2);
      set_vec(1,  0, 1'b0, 3, -7, 12, 5, 0, -7, 1);
      set_vec(2,  0, 1'b1, 4, 4, 4, 4, 0, 4, 0);
      set_vec(3,  0, 1'b0, 4, 4, 4, 4, 0, 4, 0);
      set_vec(4,  0, 1'b1, -32768, 32767, 32767, 0, 0, 32767, 1);
      set_vec(5,  0, 1'b0, 0, -1, -1, -32768, 0, -32768, 3);
      set_vec(6,  0, 1'b0, 5, 2, 9, 2, 0, 2, 1);
      set_vec(7,  0, 1'b1, -5, -3, -3, -9, 0, -3, 1);
      set_vec(8,  1, 1'b0, 1, 2, 3, 4, -32768, -32768, 4);
      set_vec(9,  1, 1'b1, 1, 2, 3, 4, -32768, 4, 3);
      set_vec(10, 1, 1'b1, 0, 0, 0, 0, 100, 100, 4);
      set_vec(11, 1, 1'b0, 7, 7, 7, 7, 7, 7, 0);

      rst = 1'b1;
      mode4 = 1'b0; mode5 = 1'b0; x4 = '0; x5 = '0;
      s_valid4 = 1'b0; s_valid5 = 1'b0; m_ready4 = 1'b1; m_ready5 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset m_valid4", m_valid4, 0);
      check("reset y4", y4, 0);
      check("reset s_ready4", s_ready4, 1);
      check("reset m_valid5", m_valid5, 0);
      check("reset y5", y5, 0);
      check("reset s_ready5", s_ready5, 1);
      @(posedge clk);
      #1;

      latency(0, 2);
      latency(8, 3);

      for (int i = 0; i < 12; i++) send(tbl[i], tbl_exp(i));
      drain();

      // Four back-to-back transactions with the sink stalled after the third edge.
      fork
         begin
            for (int i = 0; i < 4; i++) send(tbl[i], tbl_exp(i));
         end
         begin
            repeat (3) @(posedge clk);
            #1 m_ready4 = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check("stall s_ready4", s_ready4, 0);
               check("stall m_valid4", m_valid4, 1);
               if (q4.size() == 0) check("stall queue empty", 1, 0);
               else check("stall y4 held", y4, q4[0].y);
            end
            @(posedge clk);
            #1 m_ready4 = 1'b1;
         end
      join
      drain();

      // Reset with two transactions inside the 5-input pipeline.
      mode5 = tbl[8].mode;
      for (int k = 0; k < 5; k++) x5[k*W +: W] = tbl[8].x[k];
      s_valid5 = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) x5[k*W +: W] = tbl[9].x[k];
      @(posedge clk);
      #1 s_valid5 = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post-reset m_valid5", m_valid5, 0);
      check("post-reset y5", y5, 0);
      check("post-reset s_ready5", s_ready5, 1);
      repeat (5) begin
         @(negedge clk);
         check("no stale m_valid5", m_valid5, 0);
      end
      @(posedge clk);
      #1;

      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               rv.big  = ($urandom_range(0, 1) == 1);
               rv.mode = 1'($urandom_range(0, 1));
               for (int k = 0; k < 5; k++) rv.x[k] = rnd_word();
               if (!rv.big) rv.x[4] = '0;
               re = model(rv.x, rv.big ? 5 : 4, rv.mode);
               send(rv, re);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               m_ready4 = 1'($urandom_range(0, 1));
               m_ready5 = 1'($urandom_range(0, 1));
            end
         end
      join
      m_ready4 = 1'b1;
      m_ready5 = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
